// File: rtl/demuxd_buf_if.sv
// Upstream word/select handshake and per-lane delivery bundle for demuxd_buf.
// The bcast_in signal exists only when DEMUXD_BCAST_EN is defined.
interface demuxd_buf_if #(
  parameter int N    = 3,
  parameter int SELW = $clog2(N)
);
  logic                 valid_in;
  logic                 ready_out;
  logic [SELW-1:0]      sel_in;
  logic [15:0]          d_in;
`ifdef DEMUXD_BCAST_EN
  logic                 bcast_in;
`endif
  logic [N-1:0]         valid_out;
  logic [N-1:0]         ready_in;
  logic [N-1:0][15:0]   d_out;
  logic                 err_out;

`ifdef DEMUXD_BCAST_EN
  modport master (output valid_in, sel_in, d_in, bcast_in, ready_in,
                  input  ready_out, valid_out, d_out, err_out);
  modport slave  (input  valid_in, sel_in, d_in, bcast_in, ready_in,
                  output ready_out, valid_out, d_out, err_out);
`else
  modport master (output valid_in, sel_in, d_in, ready_in,
                  input  ready_out, valid_out, d_out, err_out);
  modport slave  (input  valid_in, sel_in, d_in, ready_in,
                  output ready_out, valid_out, d_out, err_out);
`endif
endinterface

// File: rtl/demuxd_buf.sv
// Registered 1-to-N demux: one buffered 16-bit word delivered to the selected lane.
// Define DEMUXD_BCAST_EN to add broadcast delivery of one word to every lane.
module demuxd_buf #(
  parameter int N = 3
) (
  input  logic        clk,
  input  logic        rst,
  demuxd_buf_if.slave bus
);
  localparam int SELW = $clog2(N);
  localparam logic [SELW:0] NLANES = (SELW+1)'(N);

`ifdef DEMUXD_BCAST_EN
  typedef enum logic [1:0] {EMPTY, FULL, BCAST} state_t;
`else
  typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif

  state_t          state_q, state_d;
  logic [15:0]     data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            err_q, err_d;
  logic            lane_done;
`ifdef DEMUXD_BCAST_EN
  logic [N-1:0]    pend_q, pend_d, pend_left;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
`ifdef DEMUXD_BCAST_EN
      pend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
`ifdef DEMUXD_BCAST_EN
      pend_q  <= pend_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    sel_d         = sel_q;
    err_d         = 1'b0;
    lane_done     = 1'b0;
    bus.valid_out = '0;
    bus.ready_out = 1'b0;
`ifdef DEMUXD_BCAST_EN
    pend_d        = pend_q;
    pend_left     = '0;
`endif
    case (state_q)
      EMPTY: bus.ready_out = 1'b1;
      FULL: begin
        bus.valid_out[sel_q] = 1'b1;
        lane_done            = bus.ready_in[sel_q];
        // Pass-through ready lets a new word replace the departing one each cycle.
        bus.ready_out        = lane_done;
      end
`ifdef DEMUXD_BCAST_EN
      BCAST: begin
        bus.valid_out = pend_q;
        pend_left     = pend_q & ~bus.ready_in;
        lane_done     = (pend_left == '0);
        bus.ready_out = lane_done;
        pend_d        = pend_left;
      end
`endif
      default: ;
    endcase

    if (lane_done) state_d = EMPTY;

    if (bus.valid_in && bus.ready_out) begin
      data_d = bus.d_in;
      sel_d  = bus.sel_in;
`ifdef DEMUXD_BCAST_EN
      if (bus.bcast_in) begin
        state_d = BCAST;
        pend_d  = '1;
      end else
`endif
      if ({1'b0, bus.sel_in} < NLANES) begin
        state_d = FULL;
      end else begin
        state_d = EMPTY;
        err_d   = 1'b1;
      end
    end
  end

  // Idle lanes present zero so downstream write ports see no stale data.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign bus.d_out[k] = bus.valid_out[k] ? data_q : 16'h0000;
  end

  assign bus.err_out = err_q;
endmodule

// File: tb/tb_demuxd_buf.sv
// Scoreboard bench for demuxd_buf (N=3); broadcast checks run when DEMUXD_BCAST_EN is defined.
module tb_demuxd_buf;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demuxd_buf_if #(.N(N)) bus ();
  demuxd_buf #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    int          lane;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   err_exp = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every lane handshake and every err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (bus.valid_out[k] && bus.ready_in[k]) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_delivery: lane %0d data %h, want none", k, bus.d_out[k]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("deliv_lane", 64'(k), 64'(e.lane));
            chk("deliv_data", 64'(bus.d_out[k]), 64'(e.data));
          end
        end
      end
      if (bus.err_out) begin
        n_cmp++;
        if (err_exp > 0) err_exp--;
        else begin
          n_bad++;
          $display("FAIL unexpected_err: err_out 1, want 0");
        end
      end
    end
  end

  // Presents a word and waits for acceptance; leaves valid_in high on return (posedge+1).
  task automatic send(input logic [1:0] sel, input logic [15:0] d, input bit bc, output int cyc);
    bus.valid_in = 1'b1;
    bus.sel_in   = sel;
    bus.d_in     = d;
`ifdef DEMUXD_BCAST_EN
    bus.bcast_in = bc;
`endif
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.ready_out) break;
      if (cyc >= 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: ready_out 0 for %0d cycles, want 1", cyc);
        break;
      end
    end
    if (bus.ready_out && !bc) begin
      if (sel < 2'(N)) exp_q.push_back('{lane: int'(sel), data: d});
      else err_exp++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
`ifdef DEMUXD_BCAST_EN
    bus.bcast_in = 1'b0;
`endif
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c, tot;
    bus.valid_in = 1'b0;
    bus.sel_in   = '0;
    bus.d_in     = '0;
    bus.ready_in = 3'b111;
`ifdef DEMUXD_BCAST_EN
    bus.bcast_in = 1'b0;
`endif
    #1;
    chk("rst_valid", 64'(bus.valid_out), 64'h0);
    chk("rst_err", 64'(bus.err_out), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 64'(bus.ready_out), 64'h1);
    chk("rel_dout", 64'(bus.d_out), 64'h0);
    @(posedge clk); #1;

    // Unicast to lane 2
    send(2'd2, 16'hA5A5, 1'b0, c);
    idle(0);
    @(negedge clk);
    chk("uni_valid", 64'(bus.valid_out), 64'h4);
    chk("uni_d0", 64'(bus.d_out[0]), 64'h0);
    chk("uni_d1", 64'(bus.d_out[1]), 64'h0);
    @(posedge clk); #1;

    // Backpressure on lane 1 then same-cycle replacement to lane 0
    bus.ready_in = 3'b101;
    send(2'd1, 16'h1234, 1'b0, c);
    idle(0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.valid_out), 64'h2);
      chk("bp_data", 64'(bus.d_out[1]), 64'h1234);
      chk("bp_ready", 64'(bus.ready_out), 64'h0);
    end
    @(posedge clk); #1;
    bus.ready_in = 3'b111;
    send(2'd0, 16'h5678, 1'b0, c);
    chk("bp_swap_cycles", 64'(c), 64'h1);
    idle(0);
    @(negedge clk);
    chk("bp_next_valid", 64'(bus.valid_out), 64'h1);
    @(posedge clk); #1;

    // Streaming to alternating lanes: one accept per cycle
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send(2'(i % 2), 16'h1000 + 16'(i), 1'b0, c);
      tot += c;
    end
    chk("stream_cycles", 64'(tot), 64'd8);
    idle(2);

    // Out-of-range select from EMPTY
    send(2'd3, 16'hDEAD, 1'b0, c);
    idle(0);
    @(negedge clk);
    chk("oor_valid", 64'(bus.valid_out), 64'h0);
    @(posedge clk); #1;
    send(2'd0, 16'h0042, 1'b0, c);
    idle(2);

    // Out-of-range select accepted while the current delivery completes
    send(2'd1, 16'h1111, 1'b0, c);
    send(2'd3, 16'hBAD0, 1'b0, c);
    idle(0);
    @(negedge clk);
    chk("oor_full_valid", 64'(bus.valid_out), 64'h0);
    @(posedge clk); #1;
    idle(2);

`ifdef DEMUXD_BCAST_EN
    bus.ready_in = 3'b000;
    send(2'd3, 16'hBEEF, 1'b1, c);
    exp_q.push_back('{lane: 2, data: 16'hBEEF});
    exp_q.push_back('{lane: 0, data: 16'hBEEF});
    exp_q.push_back('{lane: 1, data: 16'hBEEF});
    idle(0);
    @(negedge clk);
    chk("bc_valid0", 64'(bus.valid_out), 64'h7);
    chk("bc_ready0", 64'(bus.ready_out), 64'h0);
    @(posedge clk); #1;
    bus.ready_in = 3'b100;
    @(negedge clk);
    chk("bc_valid1", 64'(bus.valid_out), 64'h7);
    chk("bc_ready1", 64'(bus.ready_out), 64'h0);
    @(posedge clk); #1;
    bus.ready_in = 3'b001;
    @(negedge clk);
    chk("bc_valid2", 64'(bus.valid_out), 64'h3);
    chk("bc_ready2", 64'(bus.ready_out), 64'h0);
    @(posedge clk); #1;
    bus.ready_in = 3'b010;
    @(negedge clk);
    chk("bc_valid3", 64'(bus.valid_out), 64'h2);
    chk("bc_ready3", 64'(bus.ready_out), 64'h1);
    @(posedge clk); #1;
    bus.ready_in = 3'b000;
    @(negedge clk);
    chk("bc_valid4", 64'(bus.valid_out), 64'h0);
    @(posedge clk); #1;
    bus.ready_in = 3'b111;
`endif

    // Reset while holding a word for lane 1
    bus.ready_in = 3'b000;
    send(2'd1, 16'h7777, 1'b0, c);
    idle(0);
    @(negedge clk);
    chk("mid_valid", 64'(bus.valid_out), 64'h2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.valid_out), 64'h0);
    chk("mid_rst_dout", 64'(bus.d_out), 64'h0);
    chk("mid_rst_err", 64'(bus.err_out), 64'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ready_in = 3'b111;
    @(negedge clk);
    chk("mid_rel_ready", 64'(bus.ready_out), 64'h1);
    chk("mid_rel_valid", 64'(bus.valid_out), 64'h0);

    repeat (3) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
    chk("err_drained", 64'(err_exp), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
